// File: rtl/data_send_pkg.sv
// Shared definitions for the framed serial sender: parity modes, FSM
// state encoding and a width helper for sizing counters.
package data_send_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Bits needed to index `value` entries; never less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Full is registered from the next-state count so it is glitch-free.
module sync_fifo
    import data_send_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses writes; an empty one ignores reads.
    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer, occupancy and full-flag registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the count alone decides which entries are valid.
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/data_send_frame.sv
// Buffered asynchronous-frame serial transmitter: start bit, DATA_W bits
// LSB first, optional parity, STOP_BITS stop bits. txd, done and overflow
// are registered; txd follows the FSM state by one clock.
module data_send_frame
    import data_send_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              ready,
    output logic              txd,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W  = clog2(DATA_W);
    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE != PAR_NONE);

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              overflow_q;

    logic [DATA_W-1:0] fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;
    logic              baud_last;
    logic              pop_parity;

    assign push = start && !fifo_full;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (data_in),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_last  = (baud_q == BAUD_LAST);
    assign pop_parity = (PARITY_MODE == PAR_ODD) ? ~(^fifo_rd) : ^fifo_rd;

    // Frame sequencing: bit timing, shifting, and popping the next word.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        baud_d  = (state_q == IDLE || baud_last) ? '0 : baud_q + BAUD_W'(1);

        unique case (state_q)
            IDLE: begin
                bit_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd;
                    par_d   = pop_parity;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) state_d = DATA;
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_last) state_d = STOP;
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next frame when a word is waiting.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_rd;
                            par_d   = pop_parity;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the current state, registered one cycle later.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            overflow_q <= start && fifo_full;
        end
    end

    assign ready    = !fifo_full;
    assign txd      = txd_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_data_send_frame.sv
// Directed bench for data_send_frame: four instances cover no parity,
// even parity, odd parity and two stop bits at 4 clocks per bit.
module tb_data_send_frame;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst, start, ready, txd, busy, done, overflow;
    logic [7:0] din [4];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_send_frame #(
            .DATA_W       (8),
            .CLKS_PER_BIT (CPB),
            .PARITY_MODE  (g == 1 ? 1 : (g == 2 ? 2 : 0)),
            .STOP_BITS    (g == 3 ? 2 : 1),
            .FIFO_DEPTH   (4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .data_in  (din[g]),
            .start    (start[g]),
            .ready    (ready[g]),
            .txd      (txd[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .overflow (overflow[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one edge, then scramble data_in.
    task automatic write(input int u, input logic [7:0] d);
        start[u] = 1'b1;
        din[u]   = d;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        din[u]   = ~d;
    endtask

    // Wait for a start bit, then check every bit cell and the done pulse.
    task automatic capture(input int u, input logic [15:0] exp, input int nbits,
                           input string tag, output int gap);
        int cyc;
        int dn;
        int done_at;
        logic [3:0] s;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (txd[u] !== 1'b0 && gap < 400);
        check({tag, "_found"}, 32'(gap < 400), 32'd1);
        if (gap >= 400) return;
        cyc = 0;
        dn = 0;
        done_at = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < CPB; k++) begin
                if (cyc != 0) @(negedge clk);
                cyc++;
                s[k] = txd[u];
                if (done[u]) begin
                    dn++;
                    done_at = cyc;
                end
            end
            check($sformatf("%s_bit%0d", tag, b), 32'(s), 32'({4{exp[b]}}));
        end
        check({tag, "_done_cnt"}, 32'(dn), 32'd1);
        check({tag, "_done_cyc"}, 32'(done_at), 32'(nbits * CPB));
    endtask

    task automatic idle_watch(input int u, input string tag);
        int lows;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd[u] !== 1'b1) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int w;
        rst   = 4'hF;
        start = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++)
            check($sformatf("reset_u%0d", u),
                  32'({txd[u], ready[u], busy[u], done[u], overflow[u]}), 32'b11000);
        rst = 4'h0;
        @(posedge clk);
        #1;

        // Single 0xA5 frame, no parity, one stop bit.
        write(0, 8'hA5);
        check("a5_busy", 32'(busy[0]), 32'd1);
        capture(0, 16'({1'b1, 8'hA5, 1'b0}), 10, "a5", gap);
        check("a5_latency", 32'(gap), 32'd3);
        @(negedge clk);
        check("a5_busy_drop", 32'(busy[0]), 32'd0);
        check("a5_done_single", 32'(done[0]), 32'd0);

        // Even and odd parity on 0x07 (three ones).
        @(posedge clk);
        #1;
        write(1, 8'h07);
        capture(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, "even", gap);
        @(posedge clk);
        #1;
        write(2, 8'h07);
        capture(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, "odd", gap);

        // Three back-to-back words.
        @(posedge clk);
        #1;
        fork
            begin
                write(0, 8'h11);
                write(0, 8'h22);
                write(0, 8'h33);
            end
            begin
                capture(0, 16'({1'b1, 8'h11, 1'b0}), 10, "b2b0", gap);
                capture(0, 16'({1'b1, 8'h22, 1'b0}), 10, "b2b1", gap);
                check("b2b1_gap", 32'(gap), 32'd1);
                capture(0, 16'({1'b1, 8'h33, 1'b0}), 10, "b2b2", gap);
                check("b2b2_gap", 32'(gap), 32'd1);
            end
        join
        idle_watch(0, "b2b_idle");

        // Six writes into a depth-4 FIFO: the sixth overflows.
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    if (i == 4) check("ovf_ready_hi", 32'(ready[0]), 32'd1);
                    write(0, 8'(i + 1));
                end
                check("ovf_ready_low", 32'(ready[0]), 32'd0);
                write(0, 8'hEE);
                check("ovf_pulse", 32'(overflow[0]), 32'd1);
                @(posedge clk);
                #1;
                check("ovf_pulse_end", 32'(overflow[0]), 32'd0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [7:0] d;
                    d = 8'(i + 1);
                    capture(0, 16'({1'b1, d, 1'b0}), 10, $sformatf("ovf%0d", i), gap);
                    if (i > 0) check($sformatf("ovf%0d_gap", i), 32'(gap), 32'd1);
                end
            end
        join
        idle_watch(0, "ovf_dropped");
        check("ovf_busy_end", 32'(busy[0]), 32'd0);

        // Reset in the middle of a frame with a second word queued.
        @(posedge clk);
        #1;
        write(0, 8'h5A);
        write(0, 8'h3C);
        w = 0;
        while (txd[0] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rst_frame_found", 32'(w < 50), 32'd1);
        repeat (14) @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_state", 32'({txd[0], busy[0], ready[0]}), 32'b101);
        rst[0] = 1'b0;
        idle_watch(0, "rst_queue_dropped");
        @(posedge clk);
        #1;
        write(0, 8'hC3);
        capture(0, 16'({1'b1, 8'hC3, 1'b0}), 10, "post_rst", gap);
        check("post_rst_latency", 32'(gap), 32'd3);

        // Two stop bits, back-to-back frames.
        @(posedge clk);
        #1;
        fork
            begin
                write(3, 8'h81);
                write(3, 8'h7E);
            end
            begin
                capture(3, 16'({2'b11, 8'h81, 1'b0}), 11, "stop2a", gap);
                capture(3, 16'({2'b11, 8'h7E, 1'b0}), 11, "stop2b", gap);
                check("stop2b_gap", 32'(gap), 32'd1);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_send_frame.md
Name: data_send_frame

Overview:
Parametrised successor to the single-byte serial sender. It accepts words through a start/ready write handshake and buffers them in a small synchronous FIFO. Each word is serialised onto txd as an asynchronous frame: start bit, DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between the packet-assembly logic and the physical serial pin of the eth subsystem.

Parameters:
DATA_W, 8, data bits per frame (5..16)
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
PARITY_MODE, 0, 0 none / 1 even / 2 odd
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, words of input buffering (power of 2, >=2)

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous reset, active-high
data_in  in  DATA_W  word to transmit
start  in  1  write strobe; word accepted when start && ready
ready  out  1  FIFO not full (registered)
txd  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
done  out  1  1-cycle pulse at the end of each frame's last stop bit
overflow  out  1  1-cycle pulse when start is asserted while ready=0; word dropped

Behaviour:
- Reset (sync, rst=1 at edge): txd=1, ready=1, busy=0, done=0, overflow=0. FIFO is emptied, state returns to IDLE, bit and baud counters are cleared. A reset mid-frame truncates the frame; txd is high from the next cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, then go to START with txd=0 on the next edge.
- Each bit lasts exactly CLKS_PER_BIT cycles, counted by a baud counter from 0 to CLKS_PER_BIT-1.
- START (1 bit) -> DATA (DATA_W bits, LSB first) -> PARITY (1 bit, only if PARITY_MODE!=0) -> STOP (STOP_BITS bits, txd=1).
- Parity: even mode sends XOR of the data bits; odd mode sends its inverse. It is computed on the popped word.
- Frame length: CLKS_PER_BIT*(1+DATA_W+(PARITY_MODE!=0)+STOP_BITS) cycles.
- Latency: with the FIFO empty and state IDLE, start at edge N makes txd=0 from edge N+2.
- End of the last stop bit:
  - done=1 for one cycle.
  - If the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Push when full: rejected, FIFO is unchanged, overflow pulses. Push and pop in the same cycle when not full: both succeed and the count is unchanged.
- ready = (count < FIFO_DEPTH), registered from the next-state count, so it deasserts in the cycle after the filling write.
- busy = (state!=IDLE) || (count!=0).
- data_in changes after acceptance do not affect queued or in-flight words.

Decomposition:
- Package data_send_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the state encoding (IDLE=0..STOP=4);
  - a width function clog2 for counter sizing.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, synchronous reset. The frame FSM, baud counter and shift register stay in data_send_frame.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, no parity, 1 stop. Write 0xA5 -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; 40-cycle frame; done pulses once at cycle 40; busy then drops.
- PARITY_MODE=1, write 0x07 -> parity bit 1. PARITY_MODE=2, write 0x07 -> parity bit 0. Frame length 44 cycles.
- Write 0x11, 0x22, 0x33 on consecutive cycles -> three frames with no idle cycle between the stop bit and the next start bit; done pulses 3 times, 40 cycles apart.
- FIFO_DEPTH=4, write 6 words on consecutive cycles while idle -> first word popped, next 4 queued, 6th write sees ready=0: overflow pulse, word absent from txd output.
- Reset asserted at cycle 15 of a frame -> txd=1 from the next cycle, busy=0, ready=1; a queued word is never sent. A new write afterwards transmits normally.
- STOP_BITS=2 -> stop high for 8 cycles; back-to-back start bit follows immediately.
